// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic        FETCH_IDLE = 1'b0;
    localparam logic        FETCH_WAIT = 1'b1;
    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef struct packed {
        logic [31:0]           pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_dat,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: sequential PCs, one outstanding fetch, PC-tagged queue to decode.
// Latency: response in cycle N -> out_valid in N+1; issue rate 1 per (mem latency + 1) cycles.
// Backpressure: no issue while queue full or exited; redirect flushes. FETCH_PERF_COUNTERS_EN adds counters.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exited,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  mem_inst_start,
    input  logic                  mem_inst_ready,
    output logic [31:0]           mem_i_addr,
    input  logic [INST_WIDTH-1:0] mem_inst,
    input  logic                  mem_inst_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [INST_WIDTH-1:0] out_inst
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_discarded,
    output logic [31:0]           perf_full_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             state;
    logic [31:0]      fetch_pc;
    logic             discard;
    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic [CW-1:0]    q_count;
    fetch_entry_t     push_ent;
    fetch_entry_t     head_ent;

    // Only one fetch is ever in flight, so no slot beyond count needs reserving.
    assign issue = !rst && (state == FETCH_IDLE) && mem_inst_ready && !redirect_valid
                   && !exited && (q_count < CW'(DEPTH));
    assign resp  = (state == FETCH_WAIT) && mem_inst_valid;
    assign push  = resp && !discard && !redirect_valid && !q_full;
    assign pop   = out_valid && out_ready && !redirect_valid;

    assign push_ent       = '{pc: fetch_pc, inst: mem_inst};
    assign mem_inst_start = issue;
    assign mem_i_addr     = fetch_pc;
    assign out_valid      = !q_empty;
    assign out_pc         = out_valid ? head_ent.pc   : '0;
    assign out_inst       = out_valid ? head_ent.inst : '0;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_dat (push_ent),
        .head_dat (head_ent),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            // A response still on its way belongs to the old stream.
            if ((state == FETCH_WAIT) && !mem_inst_valid) begin
                discard <= 1'b1;
            end else begin
                state   <= FETCH_IDLE;
                discard <= 1'b0;
            end
        end else if (state == FETCH_IDLE) begin
            if (issue) state <= FETCH_WAIT;
        end else if (mem_inst_valid) begin
            if (!discard) fetch_pc <= fetch_pc + PC_STEP;
            discard <= 1'b0;
            state   <= FETCH_IDLE;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched    <= '0;
            perf_discarded  <= '0;
            perf_full_stall <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (resp && (discard || redirect_valid)) perf_discarded <= perf_discarded + 32'd1;
            if ((state == FETCH_IDLE) && mem_inst_ready && q_full)
                perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, exited, redirect_valid, mem_inst_ready, mem_inst_valid, out_ready;
    logic [31:0] redirect_pc, mem_inst;
    logic        start_a, start_w, ov_a, ov_w;
    logic [31:0] addr_a, addr_w, opc_a, opc_w, oinst_a, oinst_w;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] pf_a, pd_a, ps_a, pf_w, pd_w, ps_w;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .exited(exited), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_inst_start(start_a), .mem_inst_ready(mem_inst_ready),
        .mem_i_addr(addr_a), .mem_inst(mem_inst), .mem_inst_valid(mem_inst_valid),
        .out_valid(ov_a), .out_ready(out_ready), .out_pc(opc_a), .out_inst(oinst_a)
`ifdef FETCH_PERF_COUNTERS_EN
        , .perf_fetched(pf_a), .perf_discarded(pd_a), .perf_full_stall(ps_a)
`endif
    );

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .exited(exited), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_inst_start(start_w), .mem_inst_ready(mem_inst_ready),
        .mem_i_addr(addr_w), .mem_inst(mem_inst), .mem_inst_valid(mem_inst_valid),
        .out_valid(ov_w), .out_ready(out_ready), .out_pc(opc_w), .out_inst(oinst_w)
`ifdef FETCH_PERF_COUNTERS_EN
        , .perf_fetched(pf_w), .perf_discarded(pd_w), .perf_full_stall(ps_w)
`endif
    );

    // reference model: fetch state, PCs of both instances, queue contents
    bit          m_init, m_wait, m_disc;
    logic [31:0] m_pc [2];
    logic [31:0] q_pc0[$], q_pc1[$], q_inst[$];
    int unsigned m_fet, m_dis, m_stall;

    // memory environment and knobs
    bit          e_pend;
    int          e_cnt, lat;
    logic [31:0] e_word;
    bit          k_rst, k_exit, redir_arm, rnd_mode;
    int          k_ordy, k_rdy;
    logic [31:0] redir_pc_k;

    // observation logs
    logic [31:0] lg_iss[$], lg_pop[$], lg_pop_w[$], lg_popi[$];
    int          lg_iss_cyc[$];
    int          first_ov, first_mv, cyc;
    int          total, bad;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic bit pred_start();
        return !rst && !m_wait && mem_inst_ready && !redirect_valid && !exited
               && (q_inst.size() < DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit ps;
        ps = pred_start();
        chk("start_a", 32'(start_a), 32'(ps));
        chk("start_w", 32'(start_w), 32'(ps));
        chk("addr_a", addr_a, m_pc[0]);
        chk("addr_w", addr_w, m_pc[1]);
        chk("ov_a", 32'(ov_a), 32'(q_inst.size() > 0));
        chk("ov_w", 32'(ov_w), 32'(q_inst.size() > 0));
        if (q_inst.size() > 0) begin
            chk("pc_a", opc_a, q_pc0[0]);
            chk("pc_w", opc_w, q_pc1[0]);
            chk("inst_a", oinst_a, q_inst[0]);
            chk("inst_w", oinst_w, q_inst[0]);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf_fetched", pf_a, m_fet);
        chk("perf_discarded", pd_a, m_dis);
        chk("perf_full_stall", ps_a, m_stall);
        chk("perf_fetched_w", pf_w, m_fet);
`endif
        if (start_a) begin lg_iss.push_back(addr_a); lg_iss_cyc.push_back(cyc); end
        if (ov_a && out_ready) begin
            lg_pop.push_back(opc_a); lg_popi.push_back(oinst_a); lg_pop_w.push_back(opc_w);
        end
        if (ov_a && first_ov < 0) first_ov = cyc;
        if (mem_inst_valid && first_mv < 0) first_mv = cyc;
    endtask

    task automatic model_update();
        bit ps, resp;
        if (rst) begin
            m_init = 1; m_wait = 0; m_disc = 0;
            m_pc[0] = 32'h0; m_pc[1] = 32'hFFFF_FFFC;
            q_pc0.delete(); q_pc1.delete(); q_inst.delete();
            m_fet = 0; m_dis = 0; m_stall = 0; e_pend = 0;
            return;
        end
        if (!m_init) return;
        ps   = pred_start();
        resp = m_wait && mem_inst_valid;
        if (!m_wait && mem_inst_ready && q_inst.size() == DEPTH) m_stall++;
        if (resp && (m_disc || redirect_valid)) m_dis++;
        if (ps) begin e_pend = 1; e_cnt = lat; e_word = word_of(m_pc[0]); end
        if (redirect_valid) begin
            q_pc0.delete(); q_pc1.delete(); q_inst.delete();
            m_pc[0] = {redirect_pc[31:2], 2'b00};
            m_pc[1] = m_pc[0];
            if (m_wait && !mem_inst_valid) m_disc = 1;
            else begin m_wait = 0; m_disc = 0; end
        end else begin
            if (q_inst.size() > 0 && out_ready) begin
                void'(q_pc0.pop_front()); void'(q_pc1.pop_front()); void'(q_inst.pop_front());
            end
            if (resp) begin
                if (!m_disc) begin
                    q_pc0.push_back(m_pc[0]); q_pc1.push_back(m_pc[1]); q_inst.push_back(mem_inst);
                    m_fet++;
                    m_pc[0] = m_pc[0] + 32'd4; m_pc[1] = m_pc[1] + 32'd4;
                end
                m_disc = 0; m_wait = 0;
            end else if (ps) begin
                m_wait = 1;
            end
        end
    endtask

    task automatic drive();
        rst = k_rst; redirect_valid = redir_arm; redirect_pc = redir_pc_k; redir_arm = 0;
        if (rnd_mode) begin
            rst            = ($urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 39) == 0) k_exit = !k_exit;
            lat = $urandom_range(1, 4);
        end
        exited = k_exit;
        if (e_pend) begin
            mem_inst_ready = 0;
            if (e_cnt == 1) begin mem_inst_valid = 1; mem_inst = e_word; e_pend = 0; end
            else begin e_cnt--; mem_inst_valid = 0; mem_inst = $urandom; end
        end else begin
            mem_inst_valid = 0; mem_inst = $urandom;
            mem_inst_ready = (k_rdy == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        case (k_ordy)
            0:       out_ready = 0;
            1:       out_ready = 1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = mem_inst_valid;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_init) compare();
        @(posedge clk);
        model_update();
        #1;
        drive();
        cyc++;
    endtask

    task automatic clear_logs();
        lg_iss.delete(); lg_iss_cyc.delete(); lg_pop.delete(); lg_pop_w.delete(); lg_popi.delete();
        first_ov = -1; first_mv = -1;
    endtask

    task automatic do_reset();
        k_rst = 1; redir_arm = 0; k_exit = 0;
        tick(); tick();
        k_rst = 0;
        tick();
        clear_logs();
    endtask

    task automatic wait_iss(input int n, input int lim);
        int k;
        k = 0;
        while (lg_iss.size() < n && k < lim) begin tick(); k++; end
        chk("wait_issue", 32'(lg_iss.size() >= n), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; m_init = 0; e_pend = 0; lat = 2;
        k_rst = 1; k_exit = 0; redir_arm = 0; redir_pc_k = 0; rnd_mode = 0; k_ordy = 1; k_rdy = 1;
        clear_logs();
        drive();

        // reset state and sequential fetch with latency 2
        do_reset();
        #1;
        chk("rst_addr_a", addr_a, 32'h0);
        chk("rst_addr_w", addr_w, 32'hFFFF_FFFC);
        chk("rst_ov", 32'(ov_a), 32'd0);
        chk("rst_pc", opc_a, 32'h0);
        chk("rst_inst", oinst_a, 32'h0);
        repeat (12) tick();
        chk("seq_iss0", qat(lg_iss, 0), 32'h0);
        chk("seq_iss1", qat(lg_iss, 1), 32'h4);
        chk("seq_iss2", qat(lg_iss, 2), 32'h8);
        chk("seq_space1", 32'(qat(lg_iss_cyc, 1) - qat(lg_iss_cyc, 0)), 32'd3);
        chk("seq_space2", 32'(qat(lg_iss_cyc, 2) - qat(lg_iss_cyc, 1)), 32'd3);
        chk("seq_first_ov", 32'(first_ov - first_mv), 32'd1);
        chk("seq_pop0", qat(lg_pop, 0), 32'h0);
        chk("seq_pop1", qat(lg_pop, 1), 32'h4);
        chk("seq_pop2", qat(lg_pop, 2), 32'h8);
        chk("seq_inst0", qat(lg_popi, 0), word_of(32'h0));
        chk("wrap_pop0", qat(lg_pop_w, 0), 32'hFFFF_FFFC);
        chk("wrap_pop1", qat(lg_pop_w, 1), 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        #1 chk("seq_perf_fetched", pf_a, 32'd4);
`endif

        // fill to full, then a single pop releases exactly one fetch
        k_ordy = 0;
        do_reset();
        repeat (20) tick();
        chk("full_issues", 32'(lg_iss.size()), 32'd4);
        chk("full_ov", 32'(ov_a), 32'd1);
        k_ordy = 1; tick(); k_ordy = 0;
        clear_logs();
        repeat (12) tick();
        chk("full_pops", 32'(lg_pop.size()), 32'd1);
        chk("full_pop_pc", qat(lg_pop, 0), 32'h0);
        chk("full_reissue", 32'(lg_iss.size()), 32'd1);
        chk("full_reissue_pc", qat(lg_iss, 0), 32'h10);

        // redirect while waiting: queued entry flushed, returning word dropped
        lat = 3; k_ordy = 0;
        do_reset();
        wait_iss(2, 20);
        redir_arm = 1; redir_pc_k = 32'h100;
        tick(); tick();
        #1 chk("redir_flush_ov", 32'(ov_a), 32'd0);
        k_ordy = 1;
        clear_logs();
        repeat (15) tick();
        chk("redir_iss", qat(lg_iss, 0), 32'h100);
        chk("redir_pop", qat(lg_pop, 0), 32'h100);
`ifdef FETCH_PERF_COUNTERS_EN
        #1 chk("redir_perf_disc", pd_a, 32'd1);
`endif

        // redirect coinciding with the response, misaligned target
        lat = 2; k_ordy = 1;
        do_reset();
        wait_iss(1, 10);
        redir_arm = 1; redir_pc_k = 32'h203;
        clear_logs();
        repeat (12) tick();
        chk("coin_iss", qat(lg_iss, 0), 32'h200);
        chk("coin_pop", qat(lg_pop, 0), 32'h200);
`ifdef FETCH_PERF_COUNTERS_EN
        #1 chk("coin_perf_disc", pd_a, 32'd1);
`endif

        // exited: outstanding response accepted, queue drains, nothing new issued
        lat = 2; k_ordy = 0;
        do_reset();
        wait_iss(3, 20);
        k_exit = 1; k_ordy = 1;
        clear_logs();
        repeat (20) tick();
        chk("exit_issues", 32'(lg_iss.size()), 32'd0);
        chk("exit_pops", 32'(lg_pop.size()), 32'd3);
        chk("exit_pop0", qat(lg_pop, 0), 32'h0);
        chk("exit_pop2", qat(lg_pop, 2), 32'h8);

        // simultaneous push and pop holding two entries
        lat = 1; k_ordy = 0;
        do_reset();
        for (int k = 0; k < 20 && q_inst.size() < 2; k++) tick();
        chk("pp_fill", 32'(q_inst.size()), 32'd2);
        k_ordy = 3;
        clear_logs();
        repeat (12) tick();
        chk("pp_pop0", qat(lg_pop, 0), 32'h0);
        chk("pp_order", qat(lg_pop, 1), qat(lg_pop, 0) + 32'd4);
        k_exit = 1;
        repeat (4) tick();
        k_ordy = 1;
        clear_logs();
        repeat (8) tick();
        chk("pp_left", 32'(lg_pop.size()), 32'd2);

        // random traffic
        k_exit = 0; k_ordy = 2; k_rdy = 2;
        do_reset();
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
